// File: rtl/redirect_pkg.sv
// Shared types and constants for the branch redirect unit.
// Holds the redirect FSM state enum and counter/alignment constants.
package redirect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } redirect_state_t;

  localparam int FLUSH_CNT_W = 4;

  localparam logic [1:0] REDIRECT_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/redirect_flush_timer.sv
// Flush countdown: load a start value, count down to zero, flag expiry.
// Ports: clk, reset (async low), load, load_val in; expired out.
module redirect_flush_timer
  import redirect_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [FLUSH_CNT_W-1:0] load_val,
  output logic                   expired
);

  logic [FLUSH_CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/branch_redirect_unit.sv
// Turns taken jumps from execute into a held redirect plus timed flush.
// Ports: clk, reset (async low), execute_done, jump_signal, pc_target,
//   fetch_ready in; redirect_valid, redirect_pc, flush, stall_execute,
//   misalign_fault, fault_pc out. Option: BRANCH_MISALIGN_CHECK_EN.
module branch_redirect_unit
  import redirect_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              execute_done,
  input  logic              jump_signal,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              fetch_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              stall_execute,
  output logic              misalign_fault,
  output logic [ADDR_W-1:0] fault_pc
);

  localparam logic [FLUSH_CNT_W-1:0] LOAD_VAL =
    FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  redirect_state_t state, state_nxt;

  logic jump_seen;
  logic bad_align;
  logic take;
  logic load;
  logic expired;

  assign jump_seen = (state == IDLE) && execute_done && jump_signal;

`ifdef BRANCH_MISALIGN_CHECK_EN
  assign bad_align = |(pc_target[1:0] & REDIRECT_ALIGN_MASK);
`else
  assign bad_align = 1'b0;
`endif

  assign take = jump_seen && !bad_align;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE:  if (take) state_nxt = REQ;
      REQ: begin
        if (fetch_ready) begin
          load      = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: if (expired) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      redirect_pc <= '0;
    end else begin
      state <= state_nxt;
      if (take) redirect_pc <= pc_target;
    end
  end

  redirect_flush_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (LOAD_VAL),
    .expired  (expired)
  );

  assign redirect_valid = (state == REQ);
  assign flush          = (state != IDLE);
  assign stall_execute  = (state != IDLE);

`ifdef BRANCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_fault <= 1'b0;
      fault_pc       <= '0;
    end else begin
      misalign_fault <= jump_seen && bad_align;
      if (jump_seen && bad_align) fault_pc <= pc_target;
    end
  end
`else
  assign misalign_fault = 1'b0;
  assign fault_pc       = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Randomized plus directed bench for branch_redirect_unit.
// Compares every output each cycle against a behavioural model.
module tb_branch_redirect_unit;

  localparam int AW = 64;
  localparam int FC = 2;

`ifdef BRANCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          execute_done = 1'b0;
  logic          jump_signal = 1'b0;
  logic [AW-1:0] pc_target = '0;
  logic          fetch_ready = 1'b0;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic          stall_execute;
  logic          misalign_fault;
  logic [AW-1:0] fault_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  always #5 clk = ~clk;

  branch_redirect_unit #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk            (clk),
    .reset          (reset),
    .execute_done   (execute_done),
    .jump_signal    (jump_signal),
    .pc_target      (pc_target),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .stall_execute  (stall_execute),
    .misalign_fault (misalign_fault),
    .fault_pc       (fault_pc)
  );

  // behavioural model: pending request flag plus remaining flush cycles
  bit          m_pending;
  int          m_flush_left;
  logic [AW-1:0] m_pc;
  bit          m_fault;
  logic [AW-1:0] m_fpc;

  task automatic check(input string tag, input logic [AW-1:0] got,
                       input logic [AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending    = 0;
    m_flush_left = 0;
    m_pc         = '0;
    m_fault      = 0;
    m_fpc        = '0;
  endtask

  task automatic model_step(input bit d, input bit j,
                            input logic [AW-1:0] t, input bit r);
    bool_idle: begin end
    m_fault = 0;
    if (m_pending) begin
      if (r) begin
        m_pending    = 0;
        m_flush_left = FC;
        n_xfer++;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (d && j) begin
      if (MIS_EN && (t % 4 != 0)) begin
        m_fault = 1;
        m_fpc   = t;
      end else begin
        m_pending = 1;
        m_pc      = t;
      end
    end
  endtask

  task automatic compare_all();
    bit busy;
    busy = m_pending || (m_flush_left > 0);
    check("redirect_valid", AW'(redirect_valid), AW'(m_pending));
    check("redirect_pc", redirect_pc, m_pc);
    check("flush", AW'(flush), AW'(busy));
    check("stall_execute", AW'(stall_execute), AW'(busy));
    check("misalign_fault", AW'(misalign_fault), AW'(m_fault));
    check("fault_pc", fault_pc, m_fpc);
  endtask

  task automatic cyc(input bit d, input bit j,
                     input logic [AW-1:0] t, input bit r);
    @(negedge clk);
    compare_all();
    execute_done = d;
    jump_signal  = j;
    pc_target    = t;
    fetch_ready  = r;
    @(posedge clk);
    if (reset) model_step(d, j, t, r);
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      execute_done = 1'($urandom);
      jump_signal  = 1'($urandom);
      pc_target    = {$urandom, $urandom};
      fetch_ready  = 1'($urandom);
      #1 compare_all();
    end
    @(negedge clk);
    execute_done = 1'b0;
    jump_signal  = 1'b0;
    fetch_ready  = 1'b0;
    reset        = 1'b1;
  endtask

  initial begin
    model_reset();
    hold_reset(4);

    // basic redirect, fetch ready at once
    cyc(1, 1, 64'h1000, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);

    // back-pressure for five cycles
    cyc(1, 1, 64'h2040, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);

    // wrong-path jump ignored during REQ and FLUSH
    cyc(1, 1, 64'h2000, 0);
    cyc(1, 1, 64'h3000, 0);
    cyc(1, 1, 64'h3000, 1);
    cyc(1, 1, 64'h3000, 1);
    cyc(1, 1, 64'h3000, 1);
    cyc(0, 0, '0, 0);

    // done without jump
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'h4000, 1);

    // misaligned target
    cyc(1, 1, 64'h1002, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);

    // reset while waiting on fetch
    cyc(1, 1, 64'h5000, 0);
    cyc(0, 0, '0, 0);
    hold_reset(2);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      cyc(1'($urandom_range(3) != 0), 1'($urandom), t,
          $urandom_range(9) < 4);
      if ($urandom_range(99) == 0) hold_reset($urandom_range(3));
    end

    @(negedge clk);
    compare_all();
    if (n_xfer < 5) begin
      n_fail++;
      $display("FAIL xfer_count: got %0d expected >= 5", n_xfer);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
